// File: rtl/axis_sum_pkg.sv
// ------------------------------------------------------------------------
// axis_sum_pkg: FSM states, seven-segment codes and helpers. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package axis_sum_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_CONVERT = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    digit_to_seg = SEG_0;
         4'd1:    digit_to_seg = SEG_1;
         4'd2:    digit_to_seg = SEG_2;
         4'd3:    digit_to_seg = SEG_3;
         4'd4:    digit_to_seg = SEG_4;
         4'd5:    digit_to_seg = SEG_5;
         4'd6:    digit_to_seg = SEG_6;
         4'd7:    digit_to_seg = SEG_7;
         4'd8:    digit_to_seg = SEG_8;
         4'd9:    digit_to_seg = SEG_9;
         default: digit_to_seg = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [63:0] pow10(input int d);
      pow10 = 64'd1;
      for (int i = 0; i < d; i++) begin
         pow10 = pow10 * 64'd10;
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ------------------------------------------------------------------------
// bin2bcd_seq: sequential double-dabble, one bit per cycle for SW cycles. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq #(
   parameter int SW     = 12,
   parameter int DIGITS = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [SW-1:0]          bin,
   output logic                   busy,
   output logic                   done,
   output logic [DIGITS-1:0][3:0] bcd
);
   import axis_sum_pkg::*;

   localparam int CNTW = $clog2(SW + 1);

   logic [SW-1:0]          bin_q;
   logic [DIGITS-1:0][3:0] bcd_q;
   logic [DIGITS-1:0][3:0] w_adj;
   logic [DIGITS*4-1:0]    w_shift;
   logic [CNTW-1:0]        cnt_q;
   logic                   busy_q;
   logic                   done_q;

   // Digits beyond DIGITS are dropped; the top flags that range as overflow.
   always_comb begin
      w_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i] >= 4'd5) w_adj[i] = bcd_q[i] + 4'd3;
      end
      w_shift = {w_adj[DIGITS*4-2:0], bin_q[SW-1]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= CNTW'(SW);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            bin_q <= bin_q << 1;
            bcd_q <= w_shift;
            cnt_q <= cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/axis_window_sum_bcd.sv
// ------------------------------------------------------------------------
// axis_window_sum_bcd: sums N samples and presents the total as 7-segment
// digits. Option macro: LEADING_ZERO_BLANK_EN. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module axis_window_sum_bcd #(
   parameter int N      = 10,
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH-1:0]       s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DIGITS-1:0][6:0] m_data,
   output logic                   m_overflow
);
   import axis_sum_pkg::*;

   localparam int          SW      = WIDTH + $clog2(N + 1);
   localparam int          CW      = $clog2(N + 1);
   localparam logic [CW-1:0] C_LAST  = CW'(N - 1);
   localparam logic [63:0] C_POW10 = pow10(DIGITS);

   state_t                 state_q;
   logic [SW-1:0]          sum_q;
   logic [CW-1:0]          count_q;
   logic                   s_ready_q;
   logic                   m_valid_q;
   logic                   m_overflow_q;
   logic [DIGITS-1:0][6:0] m_data_q;

   logic                   w_accept;
   logic                   w_last;
   logic [SW-1:0]          w_sum_next;
   logic                   w_busy;
   logic                   w_done;
   logic [DIGITS-1:0][3:0] w_bcd;
   logic                   w_ovf;
   logic [DIGITS-1:0][6:0] w_seg;

   assign w_accept   = s_valid && s_ready_q;
   assign w_last     = (count_q == C_LAST);
   assign w_sum_next = sum_q + SW'(s_data);

   // Conversion starts on the accepting edge so m_valid lands SW+1 cycles later.
   bin2bcd_seq #(
      .SW     (SW),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rstn  (rstn),
      .start (w_accept && w_last),
      .bin   (w_sum_next),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   assign w_ovf = ({{(64-SW){1'b0}}, sum_q} >= C_POW10);

`ifdef LEADING_ZERO_BLANK_EN
   logic w_lead;
`endif

   always_comb begin
      w_seg = '0;
`ifdef LEADING_ZERO_BLANK_EN
      w_lead = 1'b1;
`endif
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_seg[i] = digit_to_seg(w_bcd[i]);
`ifdef LEADING_ZERO_BLANK_EN
         if (i > 0 && w_lead && w_bcd[i] == 4'd0) w_seg[i] = SEG_BLANK;
         else                                     w_lead   = 1'b0;
`endif
         if (w_ovf) w_seg[i] = SEG_DASH;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_ACCUM;
         sum_q        <= '0;
         count_q      <= '0;
         s_ready_q    <= 1'b1;
         m_valid_q    <= 1'b0;
         m_overflow_q <= 1'b0;
         m_data_q     <= {DIGITS{SEG_0}};
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (w_accept) begin
                  sum_q   <= w_sum_next;
                  count_q <= count_q + CW'(1);
                  if (w_last) begin
                     state_q   <= ST_CONVERT;
                     s_ready_q <= 1'b0;
                  end
               end
            end
            ST_CONVERT: begin
               if (w_done && !w_busy) begin
                  state_q      <= ST_OUTPUT;
                  m_valid_q    <= 1'b1;
                  m_data_q     <= w_seg;
                  m_overflow_q <= w_ovf;
               end
            end
            ST_OUTPUT: begin
               if (m_ready) begin
                  state_q   <= ST_ACCUM;
                  sum_q     <= '0;
                  count_q   <= '0;
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
               end
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_overflow = m_overflow_q;

endmodule

`default_nettype wire
